// File: rtl/clock_pkg.sv
// Shared definitions for the clock display path: active-high seven-segment
// glyphs (seg[0]=a .. seg[6]=g), scan-slot digit indices and the BCD digit type.
package clock_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 6;

  typedef logic [DIGIT_W-1:0] bcd_t;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Scan slot order, rightmost digit first.
  localparam logic [2:0] IDX_SEC2  = 3'd0;
  localparam logic [2:0] IDX_SEC1  = 3'd1;
  localparam logic [2:0] IDX_MIN2  = 3'd2;
  localparam logic [2:0] IDX_MIN1  = 3'd3;
  localparam logic [2:0] IDX_HOUR2 = 3'd4;
  localparam logic [2:0] IDX_HOUR1 = 3'd5;

  function automatic logic is_invalid(input bcd_t d);
    return d > 4'd9;
  endfunction

endpackage

// File: rtl/clock_display_scan_bcd_to_seg7.sv
// BCD to active-high seven-segment decoder; codes above 9 show a dash.
module bcd_to_seg7
  import clock_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Glyph lookup.
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/clock_display_scan.sv
// Multiplexed 6-digit seven-segment driver for an HH:MM:SS BCD time.
// Digits are captured into a snapshot on load, scanned one per slot with a
// one-cycle dead time at each slot change, and decorated with HH.MM.SS
// separators. Optional macro COLON_BLINK_EN makes the separators blink.
module clock_display_scan
  import clock_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter int unsigned BLINK_TICKS    = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sec1,
  input  logic [3:0] sec2,
  input  logic [3:0] min1,
  input  logic [3:0] min2,
  input  logic [3:0] hour1,
  input  logic [3:0] hour2,
  input  logic       load,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic       digit_err
);

  localparam int unsigned PRE_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] snap;
  logic                               err_q;
  logic [PRE_W-1:0]                   pre_cnt;
  logic                               tick;
  logic [2:0]                         index;
  bcd_t                               cur_digit;
  logic [6:0]                         cur_seg;
  logic                               blink_on;
  logic                               sep_slot;
  logic [5:0]                         an_q;
  logic [6:0]                         seg_q;
  logic                               dp_q;

  // Snapshot capture; digit_err is derived from the same inputs on the same
  // edge so it always describes the digits currently held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap  <= '0;
      err_q <= 1'b0;
    end else if (load) begin
      snap  <= {hour1, hour2, min1, min2, sec1, sec2};
      err_q <= is_invalid(sec1) | is_invalid(sec2) | is_invalid(min1) |
               is_invalid(min2) | is_invalid(hour1) | is_invalid(hour2);
    end
  end

  // Slot prescaler; tick marks the last cycle of each slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  assign tick = (pre_cnt == PRE_LAST);

  // Digit index, mod-6 advance on each tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      index <= IDX_SEC2;
    end else if (tick) begin
      index <= (index == IDX_HOUR1) ? IDX_SEC2 : index + 3'd1;
    end
  end

  // Select the snapshot digit for the current slot.
  always_comb begin
    cur_digit = '0;
    case (index)
      IDX_SEC2:  cur_digit = snap[0];
      IDX_SEC1:  cur_digit = snap[1];
      IDX_MIN2:  cur_digit = snap[2];
      IDX_MIN1:  cur_digit = snap[3];
      IDX_HOUR2: cur_digit = snap[4];
      IDX_HOUR1: cur_digit = snap[5];
      default:   cur_digit = '0;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd (cur_digit),
    .seg (cur_seg)
  );

`ifdef COLON_BLINK_EN
  localparam int unsigned BL_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_TICKS - 1);

  logic [BL_W-1:0] blink_cnt;

  // Separator blink phase, toggled every BLINK_TICKS slot ticks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (tick) begin
      if (blink_cnt == BL_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end
`else
  // Separator steady on for any legal BLINK_TICKS.
  assign blink_on = (BLINK_TICKS != 0);
`endif

  assign sep_slot = (index == IDX_MIN2) || (index == IDX_HOUR2);

  // Active-high output registers: dark on dead-time ticks and while blanked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_q  <= '0;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b0;
    end else if (blank || tick) begin
      an_q  <= '0;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b0;
    end else begin
      an_q  <= 6'b000001 << index;
      seg_q <= cur_seg;
      dp_q  <= sep_slot & blink_on;
    end
  end

  // Output polarity applied after the registers so reset is inactive at once.
  assign an        = an_q  ^ {6{SEG_ACTIVE_LOW}};
  assign seg       = seg_q ^ {7{SEG_ACTIVE_LOW}};
  assign dp        = dp_q  ^ SEG_ACTIVE_LOW;
  assign digit_err = err_q;

endmodule
